// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_pkg;

    localparam int PWM_DEFAULT_W = 16;

    localparam logic [15:0] PWM_RST_PERIOD = 16'hFFFF;

    // One channel's slice of the packed duty vector at the default width.
    typedef logic [PWM_DEFAULT_W-1:0] duty_slice_t;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: compare against the shared counter, apply polarity, register the pin.
module pwm_cmp_ch
    import pwm_pkg::*;
#(
    parameter int W = PWM_DEFAULT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] duty,
    input  logic         POL,
    output logic         OUT
);

    // While disabled the pin rests at its inactive level, which is the polarity bit itself.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT <= 1'b0;
        end else if (!EN) begin
            OUT <= POL;
        end else begin
            OUT <= (cnt < duty) ^ POL;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter and double-buffered period/duty.
// Center-aligned counting (CENTER port) is built only when PWM_CENTER_ALIGN_EN is defined.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int          W          = PWM_DEFAULT_W,
    parameter int          NCH        = 4,
    parameter logic [31:0] RST_PERIOD = 32'(PWM_RST_PERIOD)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LD,
    input  logic [W-1:0]     PERIOD_IN,
    input  logic [NCH*W-1:0] DUTY_IN,
    input  logic [NCH-1:0]   POL,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic             CENTER,
`endif
    output logic [NCH-1:0]   OUT,
    output logic             CYCLE_END,
    output logic             PEND
);

    localparam logic [W-1:0] RST_ACT_PERIOD = W'(RST_PERIOD);

    logic [W-1:0]          cnt;
    logic [W-1:0]          cnt_next;
    logic [W-1:0]          act_period;
    logic [W-1:0]          stg_period;
    logic [NCH-1:0][W-1:0] act_duty;
    logic [NCH-1:0][W-1:0] stg_duty;
    logic                  wrap;

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_down;
    logic dir_next;
    logic center_q;
    logic en_d;

    // Up/down sequencing; periods of 0 or 1 have no down leg and end at the top.
    always_comb begin
        cnt_next = cnt + W'(1);
        dir_next = dir_down;
        wrap     = EN && (cnt == act_period);
        if (!center_q) begin
            if (wrap) begin
                cnt_next = '0;
            end
        end else begin
            wrap = 1'b0;
            if (!dir_down) begin
                if (cnt == act_period) begin
                    if (act_period <= W'(1)) begin
                        cnt_next = '0;
                        wrap     = EN;
                    end else begin
                        cnt_next = cnt - W'(1);
                        dir_next = 1'b1;
                    end
                end
            end else begin
                cnt_next = cnt - W'(1);
                if (cnt == W'(1)) begin
                    cnt_next = '0;
                    dir_next = 1'b0;
                    wrap     = EN;
                end
            end
            if (EN && !en_d) begin
                wrap = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dir_down <= 1'b0;
            center_q <= 1'b0;
            en_d     <= 1'b0;
        end else begin
            en_d     <= EN;
            dir_down <= EN ? dir_next : 1'b0;
            if (!EN || wrap) begin
                center_q <= CENTER;
            end
        end
    end
`else
    always_comb begin
        wrap     = EN && (cnt == act_period);
        cnt_next = wrap ? '0 : cnt + W'(1);
    end
`endif

    // LD on a boundary bypasses staging; otherwise staged values wait for a boundary or idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            act_period <= RST_ACT_PERIOD;
            act_duty   <= '0;
            stg_period <= '0;
            stg_duty   <= '0;
            PEND       <= 1'b0;
            CYCLE_END  <= 1'b0;
        end else begin
            cnt       <= EN ? cnt_next : '0;
            CYCLE_END <= wrap;
            if (LD) begin
                stg_period <= PERIOD_IN;
                stg_duty   <= DUTY_IN;
            end
            if (LD && wrap) begin
                act_period <= PERIOD_IN;
                act_duty   <= DUTY_IN;
                PEND       <= 1'b0;
            end else begin
                if (PEND && (wrap || !EN)) begin
                    act_period <= stg_period;
                    act_duty   <= stg_duty;
                    PEND       <= 1'b0;
                end
                if (LD) begin
                    PEND <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_cmp_ch #(
            .W(W)
        ) u_ch (
            .CLK  (CLK),
            .RST  (RST),
            .EN   (EN),
            .cnt  (cnt),
            .duty (act_duty[i]),
            .POL  (POL[i]),
            .OUT  (OUT[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (default 16-bit, 4-channel build).
module tb_pwm_multi;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        LD;
    logic [15:0] PERIOD_IN;
    logic [63:0] DUTY_IN;
    logic [3:0]  POL;
    logic [3:0]  OUT;
    logic        CYCLE_END;
    logic        PEND;
`ifdef PWM_CENTER_ALIGN_EN
    logic        CENTER = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    pwm_multi #(
        .W(16),
        .NCH(4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .LD        (LD),
        .PERIOD_IN (PERIOD_IN),
        .DUTY_IN   (DUTY_IN),
        .POL       (POL),
`ifdef PWM_CENTER_ALIGN_EN
        .CENTER    (CENTER),
`endif
        .OUT       (OUT),
        .CYCLE_END (CYCLE_END),
        .PEND      (PEND)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle's inputs, then step past the next rising edge to sample the result.
    task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                                 input logic [15:0] period, input logic [63:0] duty,
                                 input logic [3:0] pol);
        RST       = rst;
        EN        = en;
        LD        = ld;
        PERIOD_IN = period;
        DUTY_IN   = duty;
        POL       = pol;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expOut,
                               input logic expCe, input logic expPend);
        checks++;
        assert (OUT === expOut) else begin
            errors++;
            $error("[TB] FAIL %s OUT observed=%b expected=%b", tag, OUT, expOut);
        end
        checks++;
        assert (CYCLE_END === expCe) else begin
            errors++;
            $error("[TB] FAIL %s CYCLE_END observed=%b expected=%b", tag, CYCLE_END, expCe);
        end
        checks++;
        assert (PEND === expPend) else begin
            errors++;
            $error("[TB] FAIL %s PEND observed=%b expected=%b", tag, PEND, expPend);
        end
    endtask

    // Raw compare pattern for counter value p; ch1 duty is 0 and ch2 duty (10) exceeds period 9.
    function automatic logic [3:0] rawPattern(input int p, input int d0, input int d3);
        return {logic'(p < d3), 1'b1, 1'b0, logic'(p < d0)};
    endfunction

    initial begin
        logic [63:0] duty;
        logic [3:0]  expOut;
        int          p;
        int          d0;
        int          d3;
        logic        ld;

        duty = {16'd5, 16'd10, 16'd0, 16'd3};
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 64'd0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 64'd0, 4'b0000);
        checkOutput("reset", 4'b0000, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 16'd9, duty, 4'b0000);
        checkOutput("load_idle", 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd9, duty, 4'b0000);
        checkOutput("commit_idle", 4'b0000, 1'b0, 1'b0);

        // Edge k samples counter value k%10; mid-period LD at k=23, LD on the wrap at k=49.
        for (int k = 0; k < 60; k++) begin
            ld = (k == 23) || (k == 49);
            if (k == 23) duty = {16'd5, 16'd10, 16'd0, 16'd7};
            if (k == 49) duty = {16'd8, 16'd10, 16'd0, 16'd1};
            applyStimulus(1'b0, 1'b1, ld, 16'd9, duty, 4'b0000);
            p  = k % 10;
            d0 = (k <= 29) ? 3 : ((k <= 49) ? 7 : 1);
            d3 = (k <= 49) ? 5 : 8;
            checkOutput($sformatf("run_k%0d", k), rawPattern(p, d0, d3), p == 9,
                        (k >= 23) && (k <= 28));
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 16'd9, duty, 4'b0101);
        checkOutput("pol_p0", 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd9, duty, 4'b0101);
        checkOutput("pol_p1", 4'b1001, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd9, duty, 4'b0101);
        checkOutput("en_low_0", 4'b0101, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd9, duty, 4'b0101);
        checkOutput("en_low_1", 4'b0101, 1'b0, 1'b0);
        for (int j = 0; j < 12; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'd9, duty, 4'b0101);
            p      = j % 10;
            expOut = rawPattern(p, 1, 8) ^ 4'b0101;
            checkOutput($sformatf("restart_j%0d", j), expOut, p == 9, 1'b0);
        end

        duty = {4{16'd1}};
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd0, duty, 4'b0000);
        checkOutput("p0_load", 4'b0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, duty, 4'b0000);
        checkOutput("p0_commit", 4'b0000, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, duty, 4'b0000);
            checkOutput($sformatf("p0_run%0d", j), 4'b1111, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, duty, 4'b0000);
        checkOutput("mid_reset", 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, duty, 4'b0000);
        checkOutput("post_reset", 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, duty, 4'b0000);
        checkOutput("post_reset2", 4'b0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
